flopenl_ckpt: RTL

//  Multi-channel bank of enable/synchronous-load registers with a LIFO checkpoint stack.
//  Per channel: hold, capture d on en, or force val on load.
//  The whole bank can be snapshotted (save) and rolled back (restore) to support speculative state.

---
 rtl/flopenl_ckpt_pkg.sv | 17 +
 rtl/flopenl_ckpt_lifo.sv | 46 ++++
 rtl/flopenl_ckpt.sv | 86 ++++++++
 3 files changed

// File: rtl/flopenl_ckpt_pkg.sv
// Shared types and sizing for the flopenl_ckpt register bank and its checkpoint stack.
// Bank geometry is fixed here so the top and the LIFO agree on widths.
package flopenl_ckpt_pkg;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;

    typedef logic [WIDTH-1:0] word_t;
    typedef word_t [NCH-1:0]  bank_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
endpackage

// File: rtl/flopenl_ckpt_lifo.sv
// ckpt_lifo: DEPTH-entry LIFO of whole-bank snapshots; top entry is index count-1.
// Latency: push/pop visible after one clk edge; top is a combinational read of storage.
// Backpressure: caller must not push when full or pop when empty (requests are gated upstream).
module ckpt_lifo
    import flopenl_ckpt_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  bank_t         din,
    output bank_t         top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    bank_t         mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = AW'(cnt);
    assign rd_idx = AW'(cnt - CW'(1));

    // Storage carries no reset; it is only observable through a successful pop/peek.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (push) begin
            cnt <= cnt + CW'(1);
        end else if (pop) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign top   = mem[rd_idx];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
endmodule

// File: rtl/flopenl_ckpt.sv
// flopenl_ckpt: per-channel enable/load register bank with save/restore checkpoint stack.
// Latency: one clk edge for every update. No backpressure; misuse is dropped and flagged on err
// only when FLOPENL_CKPT_ERR_EN is defined (otherwise err is tied low).
module flopenl_ckpt
    import flopenl_ckpt_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NCH-1:0]              en,
    input  logic [NCH-1:0]              load,
    input  logic [NCH-1:0][WIDTH-1:0]   d,
    input  logic [NCH-1:0][WIDTH-1:0]   val,
    input  logic                        save,
    input  logic                        restore,
    output logic [NCH-1:0][WIDTH-1:0]   q,
    output logic [CW-1:0]               count,
    output logic                        full,
    output logic                        empty,
    output logic                        err
);
    bank_t q_r;
    bank_t q_nxt;
    bank_t top;
    logic  push;
    logic  pop;
    logic  take_top;

    // Simultaneous save+restore is a peek: top is read but the stack does not move.
    assign push     = save && !restore && !full;
    assign pop      = restore && !save && !empty;
    assign take_top = restore && !empty;

    ckpt_lifo u_lifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (q_r),
        .top     (top),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        q_nxt = q_r;
        if (take_top) begin
            q_nxt = top;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load[i]) begin
                    q_nxt[i] = val[i];
                end else if (en[i]) begin
                    q_nxt[i] = d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= '0;
        end else begin
            q_r <= q_nxt;
        end
    end

    assign q = q_r;

`ifdef FLOPENL_CKPT_ERR_EN
    logic misuse;
    assign misuse = (save && restore && empty) ||
                    (save && !restore && full) ||
                    (restore && !save && empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (misuse) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule
